sgd_bias_update: RTL
====================

# sgd_bias_update

Consumes the bias-gradient vector written by the linear bias-gradient stage and applies one plain SGD step to the bias parameters: `o[i] = p[i] - lr * g[i]`, element by element, over memory regions. It sits directly downstream of the bias-gradient stage in the training datapath and is sequenced by the same go/done handshake used by every fpu block. All values are signed Q16.16 fixed point.

## Interface
- No parameters. Widths are fixed: 32-bit data, Q16.16.
- `clk` input, 1 bit: single clock.
- `rst_l` input, 1 bit: asynchronous, active-low reset.
- `p` mem_handle: bias parameter region (read).
- `g` mem_handle: gradient region (read). This is the region produced by the bias-gradient stage.
- `o` mem_handle: updated bias region (write). May alias `p`'s region.
- `lr` input, 32 bits: learning rate, Q16.16. Sampled on the WAIT->LOAD_P transition only.
- `go` input, 1 bit: start; level-held by the sequencer.
- `done` output, 1 bit: high exactly while in DONE.
- `sat` output, 1 bit: sticky saturation flag for the current run.

## Operation
- Element count is N = `g.region_end - g.region_begin`. The `p` and `o` regions are at least N words long.
- Per handle, the block drives `r_en`, `w_en`, `avail`, `ptr`, `data_store` and `write_through`. It reads `done`, `data_load`, `region_begin` and `region_end`.
- States: WAIT, LOAD_P, LOAD_G, COMPUTE, WRITE, DONE.
- WAIT -> LOAD_P when `go` is high and N != 0. On this transition:
  - load all three `ptr` from their `region_begin`;
  - latch `lr`;
  - clear `sat`.
- WAIT -> DONE when `go` is high and N == 0. No memory access occurs.
- LOAD_P: assert `p.r_en` and `p.avail` until `p.done`. On `p.done`:
  - capture `data_load` into `pv`;
  - deassert `r_en` and `avail`;
  - `p.ptr++`;
  - go to LOAD_G.
- LOAD_G: same protocol on `g`, capturing into `gv`, then go to COMPUTE.
- COMPUTE (exactly 1 cycle):
  - `prod = signed(lr) * signed(gv)`, 64 bits;
  - `step = prod >>> 16`, arithmetic shift, low 32 bits kept;
  - `res = pv - step`, evaluated at 33 bits;
  - result handling per Configuration;
  - go to WRITE.
- WRITE: assert `o.w_en` and `o.avail`, and drive `o.data_store = res`. `o.write_through` is high only while `o.ptr == o.region_begin + N - 1`. On `o.done`:
  - deassert `w_en`, `avail` and `write_through`;
  - `o.ptr++`;
  - go to DONE if this was element N-1, else go to LOAD_P.
- DONE -> WAIT when `go` is low. `done` holds while `go` stays high.
- `go` falling mid-run is ignored; the run completes.
- Changes to `lr` mid-run are ignored.
- Reset at any point forces WAIT, aborts any outstanding request, and returns every output to its reset value.

## Timing
- Reset values:
  - state WAIT;
  - `done` = 0, `sat` = 0;
  - for all handles: `r_en`, `w_en`, `avail`, `write_through`, `ptr` and `data_store` = 0;
  - internal `pv`, `gv`, `res` and `lr` latch = 0.
- Requests assert on the first cycle in the state. They stay asserted until the cycle `done` is sampled high, and drop on that same clock edge.
- Per-element latency is Lp + Lg + Lo + 4 cycles, where Lx is the memory's request-to-done cycles. The 4 covers one state-entry cycle for each of LOAD_P, LOAD_G and WRITE, plus COMPUTE.
- `done` rises the cycle after the final `o.done`. For N == 0, `done` rises the cycle after `go` is sampled.
- At most one handle has a request outstanding at any time.

## Configuration
- `SGD_SATURATE_EN` defined:
  - if `res` is outside [-2^31, 2^31-1], clamp to 0x8000_0000 or 0x7FFF_FFFF;
  - set `sat`, which stays set until the next run starts.
- `SGD_SATURATE_EN` undefined:
  - the low 32 bits of `res` are written (two's-complement wrap);
  - `sat` is tied to 0.
- The clamping of `step` from the shifted 64-bit product to 32 bits is always a plain truncation, in both builds.

## Test plan
- Single element: `lr`=0x0000_8000, p=0x0001_0000, g=0x0000_4000 -> o=0x0000_E000, `sat`=0, `write_through` high on that write, then `done`.
- Four elements: p={1.0,2.0,3.0,4.0}, g=0x0001_0000 each, `lr`=0x0000_1000 -> o={0xF000,0x1_F000,0x2_F000,0x3_F000}; `write_through` asserted only on the 4th write; `ptr` values step sequentially.
- Overflow: p=0x7FFF_0000, g=0xFFFF_0000, `lr`=0x0001_0000 -> with macro, o=0x7FFF_FFFF and `sat`=1; without macro, o=0x8000_0000 and `sat`=0.
- Empty region (`g.region_begin`==`g.region_end`), `go`=1 -> `done`=1 the next cycle; `r_en` and `w_en` never assert; dropping `go` returns the block to WAIT.
- Reset mid-run: assert `rst_l`=0 while in LOAD_G with `g.r_en` high -> all enables, `ptr`, `done` and `sat` read 0 immediately. A fresh `go` then reprocesses from `region_begin`.
- Stall and `go` drop: hold `p.done` low for 10 cycles and drop `go` during the stall -> the request stays asserted, the run completes with the correct result, `done` pulses for one cycle, and the block returns to WAIT.

Source files
------------

// File: rtl/sgd_bias_update.sv
// sgd_bias_update: one plain SGD step o[i] = p[i] - lr*g[i] over Q16.16 memory regions.
// Define SGD_SATURATE_EN to clamp out-of-range results and raise the sticky sat flag.
`timescale 1ns/1ps
module sgd_bias_update (
    input  logic        clk,
    input  logic        rst_l,
    input  logic [31:0] lr,
    input  logic        go,
    output logic        done,
    output logic        sat,
    // Bias parameter handle (read)
    output logic        p_r_en_o,
    output logic        p_w_en_o,
    output logic        p_avail_o,
    output logic [31:0] p_ptr_o,
    output logic [31:0] p_data_store_o,
    output logic        p_write_through_o,
    input  logic        p_done_i,
    input  logic [31:0] p_data_load_i,
    input  logic [31:0] p_region_begin_i,
    input  logic [31:0] p_region_end_i,
    // Gradient handle (read); its region length sets the element count
    output logic        g_r_en_o,
    output logic        g_w_en_o,
    output logic        g_avail_o,
    output logic [31:0] g_ptr_o,
    output logic [31:0] g_data_store_o,
    output logic        g_write_through_o,
    input  logic        g_done_i,
    input  logic [31:0] g_data_load_i,
    input  logic [31:0] g_region_begin_i,
    input  logic [31:0] g_region_end_i,
    // Updated bias handle (write); may alias the p region
    output logic        o_r_en_o,
    output logic        o_w_en_o,
    output logic        o_avail_o,
    output logic [31:0] o_ptr_o,
    output logic [31:0] o_data_store_o,
    output logic        o_write_through_o,
    input  logic        o_done_i,
    input  logic [31:0] o_data_load_i,
    input  logic [31:0] o_region_begin_i,
    input  logic [31:0] o_region_end_i,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_WAIT    = 3'd0,
        S_LOAD_P  = 3'd1,
        S_LOAD_G  = 3'd2,
        S_COMPUTE = 3'd3,
        S_WRITE   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] lr_q, lr_d;
    logic [31:0] pv_q, pv_d;
    logic [31:0] gv_q, gv_d;
    logic [31:0] res_q, res_d;
    logic [31:0] p_ptr_q, p_ptr_d;
    logic [31:0] g_ptr_q, g_ptr_d;
    logic [31:0] o_ptr_q, o_ptr_d;
    logic [31:0] n_q, n_d;
    logic [31:0] idx_q, idx_d;
    logic        sat_q, sat_d;

    logic [31:0] n_in;
    logic        last_elem;
    logic [63:0] lr_wide;
    logic [63:0] gv_wide;
    logic [63:0] prod;
    logic [31:0] step;
    logic [32:0] res_wide;
    logic        unused_ok;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= S_WAIT;
            lr_q    <= '0;
            pv_q    <= '0;
            gv_q    <= '0;
            res_q   <= '0;
            p_ptr_q <= '0;
            g_ptr_q <= '0;
            o_ptr_q <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lr_q    <= lr_d;
            pv_q    <= pv_d;
            gv_q    <= gv_d;
            res_q   <= res_d;
            p_ptr_q <= p_ptr_d;
            g_ptr_q <= g_ptr_d;
            o_ptr_q <= o_ptr_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            sat_q   <= sat_d;
        end
    end

    assign n_in      = g_region_end_i - g_region_begin_i;
    assign last_elem = (idx_q == n_q - 32'd1);

    // Signed 32x32 product via sign-extended 64-bit operands; step keeps bits [47:16] (plain truncation).
    assign lr_wide  = {{32{lr_q[31]}}, lr_q};
    assign gv_wide  = {{32{gv_q[31]}}, gv_q};
    assign prod     = lr_wide * gv_wide;
    assign step     = prod[47:16];
    assign res_wide = {pv_q[31], pv_q} - {step[31], step};

    always_comb begin
        state_d           = state_q;
        lr_d              = lr_q;
        pv_d              = pv_q;
        gv_d              = gv_q;
        res_d             = res_q;
        p_ptr_d           = p_ptr_q;
        g_ptr_d           = g_ptr_q;
        o_ptr_d           = o_ptr_q;
        n_d               = n_q;
        idx_d             = idx_q;
        sat_d             = sat_q;
        p_r_en_o          = 1'b0;
        p_avail_o         = 1'b0;
        g_r_en_o          = 1'b0;
        g_avail_o         = 1'b0;
        o_w_en_o          = 1'b0;
        o_avail_o         = 1'b0;
        o_data_store_o    = '0;
        o_write_through_o = 1'b0;
        done              = 1'b0;

        case (state_q)
            S_WAIT: begin
                if (go) begin
                    if (n_in != 32'd0) begin
                        state_d = S_LOAD_P;
                        p_ptr_d = p_region_begin_i;
                        g_ptr_d = g_region_begin_i;
                        o_ptr_d = o_region_begin_i;
                        lr_d    = lr;
                        sat_d   = 1'b0;
                        n_d     = n_in;
                        idx_d   = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD_P: begin
                p_r_en_o  = 1'b1;
                p_avail_o = 1'b1;
                if (p_done_i) begin
                    pv_d    = p_data_load_i;
                    p_ptr_d = p_ptr_q + 32'd1;
                    state_d = S_LOAD_G;
                end
            end
            S_LOAD_G: begin
                g_r_en_o  = 1'b1;
                g_avail_o = 1'b1;
                if (g_done_i) begin
                    gv_d    = g_data_load_i;
                    g_ptr_d = g_ptr_q + 32'd1;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
`ifdef SGD_SATURATE_EN
                // Bits 32 and 31 disagree exactly when the 33-bit result leaves the 32-bit range.
                if (res_wide[32] != res_wide[31]) begin
                    res_d = res_wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    sat_d = 1'b1;
                end else begin
                    res_d = res_wide[31:0];
                end
`else
                res_d = res_wide[31:0];
`endif
                state_d = S_WRITE;
            end
            S_WRITE: begin
                o_w_en_o          = 1'b1;
                o_avail_o         = 1'b1;
                o_data_store_o    = res_q;
                o_write_through_o = last_elem;
                if (o_done_i) begin
                    o_ptr_d = o_ptr_q + 32'd1;
                    idx_d   = idx_q + 32'd1;
                    state_d = last_elem ? S_DONE : S_LOAD_P;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (!go) begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    assign p_ptr_o           = p_ptr_q;
    assign g_ptr_o           = g_ptr_q;
    assign o_ptr_o           = o_ptr_q;
    assign p_w_en_o          = 1'b0;
    assign p_data_store_o    = '0;
    assign p_write_through_o = 1'b0;
    assign g_w_en_o          = 1'b0;
    assign g_data_store_o    = '0;
    assign g_write_through_o = 1'b0;
    assign o_r_en_o          = 1'b0;
    assign sat               = sat_q;
    assign dbg_state_o       = state_q;

    // Handle fields this block never needs, plus product bits dropped by the fixed-point shift.
    assign unused_ok = ^{p_region_end_i, o_region_end_i, o_data_load_i,
                         prod[63:48], prod[15:0], res_wide[32]};

endmodule
